// File: rtl/fft_pkg.sv
// Shared FFT constants and the cosine-table helper used by the twiddle path.
// The twiddle multiplier downstream takes FRAC_BITS from here as well.
package fft_pkg;

   localparam int LOG2N     = 6;
   localparam int N         = 1 << LOG2N;
   localparam int FRAC_BITS = 10;
   localparam int ONE_Q     = 1 << FRAC_BITS;

   localparam real PI = 3.14159265358979323846;

   // Quarter-wave cosine entry round(ONE_Q*cos(2*pi*idx/n)), evaluated at
   // elaboration only; idx stays within 0..n/4, so the value is never negative.
   function automatic int cosQ(input int idx, input int n);
      real angle;
      angle = 2.0 * PI * real'(idx) / real'(n);
      return $rtoi(real'(ONE_Q) * $cos(angle) + 0.5);
   endfunction

endpackage

// File: rtl/twiddle_feeder_if.sv
// Streaming bus of the twiddle feeder: sample input side and the aligned
// C/T output side, each with its own valid/ready pair.
interface twiddle_feeder_if #(
   parameter int DW = 12,
   parameter int SW = 3
);

   logic            in_valid;
   logic            in_ready;
   logic [2*DW-1:0] in_data;
   logic [SW-1:0]   stage;
   logic            out_valid;
   logic            out_ready;
   logic [2*DW-1:0] out_C;
   logic [2*DW-1:0] out_T;
   logic            out_last;

   modport slave (
      input  in_valid, in_data, stage, out_ready,
      output in_ready, out_valid, out_C, out_T, out_last
   );

   modport master (
      output in_valid, in_data, stage, out_ready,
      input  in_ready, out_valid, out_C, out_T, out_last
   );

endinterface

// File: rtl/twiddle_feeder_rom.sv
// Combinational twiddle lookup: folds k in 0..N/2-1 onto a quarter-wave
// cosine table and returns W_N^k = {re, im} in two's complement.
module twiddle_rom
   import fft_pkg::*;
#(
   parameter int LOG2N = fft_pkg::LOG2N,
   parameter int DW    = 12
) (
   input  logic [LOG2N-2:0] k_i,
   output logic [2*DW-1:0]  tw_o
);

   localparam int NPTS = 1 << LOG2N;
   localparam int KW   = LOG2N - 1;
   localparam int QTRN = NPTS / 4;
   localparam logic [KW:0] QTR  = (KW+1)'(NPTS / 4);
   localparam logic [KW:0] HALF = (KW+1)'(NPTS / 2);

   logic signed [DW-1:0] cosTab [0:QTRN];
   logic [KW:0]          kExt;
   logic [KW-1:0]        idxRe;
   logic [KW-1:0]        idxIm;
   logic                 negRe;
   logic signed [DW-1:0] twRe;
   logic signed [DW-1:0] twIm;

   for (genvar g = 0; g <= QTRN; g++) begin : gCos
      assign cosTab[g] = DW'(cosQ(g, NPTS));
   end

   // First quadrant reads cos directly; second quadrant mirrors about N/4 and
   // negates the real part. The imaginary part is -sin, i.e. -cos shifted by N/4.
   always_comb begin
      kExt  = {1'b0, k_i};
      negRe = 1'b0;
      idxRe = k_i;
      idxIm = '0;
      if (kExt <= QTR) begin
         idxRe = k_i;
         idxIm = KW'(QTR - kExt);
      end else begin
         negRe = 1'b1;
         idxRe = KW'(HALF - kExt);
         idxIm = KW'(kExt - QTR);
      end
      twRe = negRe ? -cosTab[idxRe] : cosTab[idxRe];
      twIm = -cosTab[idxIm];
      tw_o = {twRe, twIm};
   end

endmodule

// File: rtl/twiddle_feeder.sv
// Twiddle feeder: counts samples inside a radix-2 DIF stage frame, derives the
// twiddle index, and presents each sample with its twiddle two cycles later.
// Both pipeline stages stall together whenever the output is held.
module twiddle_feeder
   import fft_pkg::*;
#(
   parameter int LOG2N = fft_pkg::LOG2N,
   parameter int DW    = 12,
   parameter int SW    = 3
) (
   input logic             clk,
   input logic             reset,
   twiddle_feeder_if.slave bus
);

   localparam int KW = LOG2N - 1;
   localparam logic [KW-1:0] LASTJ    = '1;
   localparam logic [SW-1:0] MAXSTAGE = SW'(LOG2N - 1);

   logic            advance;
   logic            inFire;
   logic [SW-1:0]   stageClamp;
   logic [SW-1:0]   stageEff;
   logic [KW-1:0]   kMask;
   logic [KW-1:0]   k_d;
   logic [KW-1:0]   sampleIdx_d;
   logic [SW-1:0]   stageLat_d;

   logic [KW-1:0]   sampleIdx_q;
   logic [SW-1:0]   stageLat_q;

   logic            s1Valid_q;
   logic [2*DW-1:0] s1Data_q;
   logic [KW-1:0]   s1K_q;
   logic            s1Last_q;

   logic            s2Valid_q;
   logic [2*DW-1:0] s2C_q;
   logic [2*DW-1:0] s2T_q;
   logic            s2Last_q;

   logic [2*DW-1:0] romTw;

   assign advance      = !s2Valid_q || bus.out_ready;
   assign inFire       = bus.in_valid && advance;
   assign bus.in_ready = advance;

   // Stage selection: the first sample of a frame uses the live (clamped)
   // stage input, every later sample uses the value latched with it.
   always_comb begin
      stageClamp = (bus.stage > MAXSTAGE) ? MAXSTAGE : bus.stage;
      stageEff   = (sampleIdx_q == '0) ? stageClamp : stageLat_q;
      kMask      = {KW{1'b1}} >> stageEff;
      k_d        = (sampleIdx_q & kMask) << stageEff;
   end

   // Next frame position and stage latch, moving only on an accepted sample.
   always_comb begin
      sampleIdx_d = sampleIdx_q;
      stageLat_d  = stageLat_q;
      if (inFire) begin
         sampleIdx_d = (sampleIdx_q == LASTJ) ? '0 : sampleIdx_q + KW'(1);
         if (sampleIdx_q == '0) begin
            stageLat_d = stageClamp;
         end
      end
   end

   // Frame counter and latched stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sampleIdx_q <= '0;
         stageLat_q  <= '0;
      end else begin
         sampleIdx_q <= sampleIdx_d;
         stageLat_q  <= stageLat_d;
      end
   end

   // First pipeline stage captures the sample, its twiddle index and frame end.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1Valid_q <= 1'b0;
         s1Data_q  <= '0;
         s1K_q     <= '0;
         s1Last_q  <= 1'b0;
      end else if (advance) begin
         s1Valid_q <= inFire;
         if (inFire) begin
            s1Data_q <= bus.in_data;
            s1K_q    <= k_d;
            s1Last_q <= (sampleIdx_q == LASTJ);
         end
      end
   end

   twiddle_rom #(
      .LOG2N (LOG2N),
      .DW    (DW)
   ) uRom (
      .k_i  (s1K_q),
      .tw_o (romTw)
   );

   // Second pipeline stage registers the looked-up twiddle next to its sample.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2Valid_q <= 1'b0;
         s2C_q     <= '0;
         s2T_q     <= '0;
         s2Last_q  <= 1'b0;
      end else if (advance) begin
         s2Valid_q <= s1Valid_q;
         if (s1Valid_q) begin
            s2C_q    <= s1Data_q;
            s2T_q    <= romTw;
            s2Last_q <= s1Last_q;
         end
      end
   end

   assign bus.out_valid = s2Valid_q;
   assign bus.out_C     = s2C_q;
   assign bus.out_T     = s2T_q;
   assign bus.out_last  = s2Last_q;

endmodule

// File: tb/tb_twiddle_feeder.sv
// Self-checking bench for twiddle_feeder (N=64, DW=12): directed frames plus a
// randomized stream, all checked against a trigonometric reference model.
module tb_twiddle_feeder;

   typedef struct {
      logic [23:0] c;
      logic [23:0] t;
      logic        last;
   } exp_t;

   logic clk;
   logic reset;

   twiddle_feeder_if #(.DW(12), .SW(3)) dif ();

   twiddle_feeder #(
      .LOG2N (6),
      .DW    (12),
      .SW    (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (dif.slave)
   );

   int          testCount = 0;
   int          failCount = 0;
   exp_t        expQ[$];
   logic [23:0] outLog[$];
   int          lastCount = 0;
   int          mJ = 0;
   int          mS = 0;
   logic        prevStall = 1'b0;
   logic [23:0] prevC;
   logic [23:0] prevT;
   logic        prevLast;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point for every check in the bench.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      testCount++;
      if (obs !== expv) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
      end
   endtask

   function automatic int roundSym(input real x);
      if (x >= 0.0) return $rtoi(x + 0.5);
      return -$rtoi(-x + 0.5);
   endfunction

   // Reference twiddle straight from exp(-j*2*pi*k/64) in Q2.10.
   function automatic logic [23:0] modelTw(input int k);
      real th;
      int  re;
      int  im;
      th = 2.0 * 3.14159265358979323846 * real'(k) / 64.0;
      re = roundSym(1024.0 * $cos(th));
      im = -roundSym(1024.0 * $sin(th));
      return {re[11:0], im[11:0]};
   endfunction

   // Reference model and scoreboard: every accepted input predicts one output,
   // every accepted output is compared in order, and held outputs must not move.
   always @(negedge clk) begin
      exp_t e;
      int   k;
      if (reset) begin
         expQ.delete();
         mJ = 0;
         mS = 0;
         prevStall = 1'b0;
      end else begin
         if (prevStall) begin
            checkOutput("holdValid", {31'd0, dif.out_valid}, 32'd1);
            checkOutput("holdC", {8'd0, dif.out_C}, {8'd0, prevC});
            checkOutput("holdT", {8'd0, dif.out_T}, {8'd0, prevT});
            checkOutput("holdLast", {31'd0, dif.out_last}, {31'd0, prevLast});
         end
         if (dif.out_valid && !dif.out_ready)
            checkOutput("inReadyStall", {31'd0, dif.in_ready}, 32'd0);
         if (!dif.out_valid)
            checkOutput("inReadyIdle", {31'd0, dif.in_ready}, 32'd1);
         prevStall = dif.out_valid && !dif.out_ready;
         prevC     = dif.out_C;
         prevT     = dif.out_T;
         prevLast  = dif.out_last;

         if (dif.out_valid && dif.out_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("spuriousOut", 32'd1, 32'd0);
            end else begin
               e = expQ.pop_front();
               checkOutput("outC", {8'd0, dif.out_C}, {8'd0, e.c});
               checkOutput("outT", {8'd0, dif.out_T}, {8'd0, e.t});
               checkOutput("outLast", {31'd0, dif.out_last}, {31'd0, e.last});
            end
            outLog.push_back(dif.out_T);
            if (dif.out_last) lastCount++;
         end

         if (dif.in_valid && dif.in_ready) begin
            if (mJ == 0) mS = (int'(dif.stage) > 5) ? 5 : int'(dif.stage);
            k = (mJ % (32 >> mS)) << mS;
            e.c    = dif.in_data;
            e.t    = modelTw(k);
            e.last = (mJ == 31);
            expQ.push_back(e);
            mJ = (mJ + 1) % 32;
         end
      end
   end

   // Drive one clock cycle of inputs; returns just after the rising edge.
   task automatic applyStimulus(input logic v, input logic [23:0] d, input logic [2:0] s,
                                input logic ordy);
      dif.in_valid  = v;
      dif.in_data   = d;
      dif.stage     = s;
      dif.out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   task automatic streamN(input int n, input logic [2:0] s);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 24'($urandom), s, 1'b1);
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      while ((expQ.size() != 0 || dif.out_valid) && budget < 40) begin
         applyStimulus(1'b0, 24'd0, 3'd0, 1'b1);
         budget++;
      end
      if (budget >= 40) checkOutput("drainTimeout", 32'(expQ.size()), 32'd0);
   endtask

   task automatic syncFrame();
      int budget;
      budget = 0;
      while (mJ != 0 && budget < 40) begin
         applyStimulus(1'b1, 24'($urandom), 3'd0, 1'b1);
         budget++;
      end
      if (budget >= 40) checkOutput("syncTimeout", 32'(mJ), 32'd0);
   endtask

   initial begin
      int base;
      int lc;
      reset         = 1'b1;
      dif.in_valid  = 1'b0;
      dif.in_data   = '0;
      dif.stage     = '0;
      dif.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstValid", {31'd0, dif.out_valid}, 32'd0);
      checkOutput("rstC", {8'd0, dif.out_C}, 32'd0);
      checkOutput("rstT", {8'd0, dif.out_T}, 32'd0);
      checkOutput("rstLast", {31'd0, dif.out_last}, 32'd0);
      reset = 1'b0;

      // Stage 0 frame: latency and the j=0/8/16 twiddles.
      base = outLog.size();
      applyStimulus(1'b1, 24'h123456, 3'd0, 1'b1);
      checkOutput("latency1", {31'd0, dif.out_valid}, 32'd0);
      applyStimulus(1'b1, 24'h654321, 3'd0, 1'b1);
      checkOutput("latency2", {31'd0, dif.out_valid}, 32'd1);
      streamN(15, 3'd0);
      drain();
      checkOutput("s0j0", {8'd0, outLog[base]}, 32'h400000);
      checkOutput("s0j8", {8'd0, outLog[base+8]}, 32'h2D4D2C);
      checkOutput("s0j16", {8'd0, outLog[base+16]}, 32'h000C00);
      streamN(15, 3'd0);
      drain();

      // Stage 1 frame.
      base = outLog.size();
      streamN(32, 3'd1);
      drain();
      checkOutput("s1j8", {8'd0, outLog[base+8]}, 32'h000C00);
      checkOutput("s1j16", {8'd0, outLog[base+16]}, 32'h400000);

      // Stage 5 frame plus one sample of the next frame; single last flag.
      base = outLog.size();
      lc   = lastCount;
      streamN(33, 3'd5);
      drain();
      for (int i = 0; i < 33; i++) checkOutput("s5Tw", {8'd0, outLog[base+i]}, 32'h400000);
      checkOutput("s5LastCount", 32'(lastCount - lc), 32'd1);

      // Backpressure with a full pipe.
      syncFrame();
      streamN(4, 3'd2);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 24'($urandom), 3'd2, 1'b0);
         checkOutput("bpInReady", {31'd0, dif.in_ready}, 32'd0);
      end
      streamN(6, 3'd2);
      drain();

      // Stage change mid-frame is ignored; stage 7 clamps to 5.
      syncFrame();
      drain();
      base = outLog.size();
      streamN(5, 3'd2);
      streamN(27, 3'd4);
      drain();
      checkOutput("midStageJ6", {8'd0, outLog[base+6]}, 32'hD2CD2C);
      base = outLog.size();
      streamN(32, 3'd7);
      drain();
      checkOutput("clampJ3", {8'd0, outLog[base+3]}, 32'h400000);
      checkOutput("clampJ17", {8'd0, outLog[base+17]}, 32'h400000);

      // Asynchronous reset mid-frame at j=10 with a valid output.
      syncFrame();
      streamN(10, 3'd1);
      checkOutput("preRstValid", {31'd0, dif.out_valid}, 32'd1);
      dif.in_valid = 1'b0;
      #1;
      reset = 1'b1;
      #1;
      checkOutput("midRstValid", {31'd0, dif.out_valid}, 32'd0);
      checkOutput("midRstC", {8'd0, dif.out_C}, 32'd0);
      checkOutput("midRstT", {8'd0, dif.out_T}, 32'd0);
      checkOutput("midRstLast", {31'd0, dif.out_last}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      base = outLog.size();
      lc   = lastCount;
      streamN(32, 3'd3);
      drain();
      checkOutput("postRstT", {8'd0, outLog[base]}, 32'h400000);
      checkOutput("postRstLast", 32'(lastCount - lc), 32'd1);

      // Randomized traffic with random stalls and stage changes.
      for (int i = 0; i < 500; i++) begin
         applyStimulus(($urandom % 4) != 0, 24'($urandom), 3'($urandom % 8),
                       ($urandom % 4) != 0);
      end
      drain();
      checkOutput("finalEmpty", 32'(expQ.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
